ddr3_sample_streamer: RTL and testbench
=======================================

Name: ddr3_sample_streamer

Overview:
- Read-side consumer of the MIG 7-series user interface (UI) in the sound generator.
- Fetches a contiguous block of 256-bit words from DDR3 through app_* read commands.
- Buffers the words in a small credit-checked FIFO and unpacks each word into sixteen 16-bit audio samples.
- Emits one sample per sample_tick pulse to the DAC/PWM stage, with optional looping for sustained tones.

Parameters:
- FIFO_DEPTH, 4: 256-bit words buffered; power of two, at least 2.
- ADDR_STEP, 8: app_addr increment per 256-bit word (BL8 on the 32-bit DQ bus).
- CNT_W, 16: width of num_words and the internal word counters.

Ports:
- ui_clk  in  1  MIG UI clock; all logic runs on its rising edge.
- sys_rst  in  1  reset, asynchronous, active-high.
- init_calib_complete  in  1  MIG calibration done.
- app_addr  out  29  UI command address.
- app_cmd  out  3  UI command; always 3'b001 (read).
- app_en  out  1  UI command valid.
- app_rdy  in  1  UI command accept.
- app_rd_data  in  256  UI read data.
- app_rd_data_valid  in  1  UI read data strobe.
- start  in  1  one-cycle pulse; begins playback.
- stop  in  1  one-cycle pulse; aborts playback.
- base_addr  in  29  first word address; sampled on start.
- num_words  in  CNT_W  words to play; sampled on start.
- loop_en  in  1  wrap to base_addr at the end; sampled on start.
- sample_tick  in  1  one-cycle sample-rate strobe.
- sample_out  out  16  current sample.
- sample_valid  out  1  one-cycle pulse; sample_out updated.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse at the end of a non-looped or stopped playback.
- underrun  out  1  sticky; set on any tick with no data; cleared on start.

Behaviour:
- Reset values: app_en=0, app_addr=0, app_cmd=3'b001, sample_out=0, sample_valid=0, done=0, underrun=0, FIFO empty, lane=0, state IDLE.
- FSM states:
  - IDLE. On start with num_words==0: done pulses the next cycle and the FSM stays in IDLE. On any other start: latch base_addr, num_words and loop_en, clear underrun, go to WAIT_CAL.
  - WAIT_CAL: go to RUN once init_calib_complete=1.
  - RUN: issue reads; issued counter runs 0..num_words-1. On reaching num_words: loop_en=1 wraps the address to base_addr and resets the counter; loop_en=0 goes to DRAIN.
  - DRAIN: no new commands. After the last word's sample 15 is emitted, pulse done and go to IDLE.
  - STOP_WAIT: entered from RUN or DRAIN on stop. Hold any in-flight app_en until accepted. Wait for outstanding==0, flush the FIFO, set lane=0, pulse done, go to IDLE.
- Command handshake:
  - A command is accepted on the cycle where app_en&app_rdy=1.
  - Once app_en is raised, app_addr and app_en stay stable until accepted.
  - After acceptance, app_addr advances by ADDR_STEP, 29-bit modulo.
  - A new command is raised only when fifo_count+outstanding < FIFO_DEPTH, so returned data can never overflow the FIFO.
- outstanding: increments on acceptance, decrements on app_rd_data_valid. Simultaneous events net to zero.
- FIFO: push on app_rd_data_valid; pop when lane 15 is consumed. Push and pop in the same cycle are allowed when the FIFO is full.
- Unpack, on sample_tick with the FIFO non-empty:
  - sample_out <= head[16*lane +: 16], lane 0 = bits 15:0 first.
  - sample_valid pulses one cycle later (latency 1); lane increments.
  - lane 15 wraps to 0 and pops the FIFO.
- Empty FIFO on sample_tick during WAIT_CAL, RUN or DRAIN: sample_out <= 0, sample_valid pulses, underrun <= 1. There is no same-cycle bypass of arriving read data.
- Ticks in IDLE or STOP_WAIT are ignored: no sample_valid pulse.
- start outside IDLE is ignored. stop in IDLE or WAIT_CAL goes straight to IDLE with a done pulse.
- Asynchronous reset mid-burst drops all state. Read data still in flight from the MIG after reset is discarded, because outstanding is 0.

Optional Feature:
- Macro: OFFSET_BINARY_EN.
- Defined: sample_out is the stored sample with bit 15 inverted (two's complement to offset binary, for the unipolar PWM DAC). The underrun silence value becomes 16'h8000.
- Undefined: samples pass through unchanged and the silence value is 16'h0000.

Test Plan:
- Basic: calibration done, base_addr=0, num_words=2, word0 lanes = 16'h0000..16'h000F, word1 lanes = 16'h0010..16'h001F, tick every 20 cycles -> 32 samples 0x0000..0x001F in order, app_addr 0 then 8, done pulses once, busy falls.
- Backpressure: app_rdy low 5 cycles on every 2nd command -> app_en and app_addr held stable until accepted; outstanding never exceeds 4; no lost or duplicated word.
- Credit limit: ticks stopped, num_words=10 -> exactly 4 commands issued, then app_en stays 0 until lane 15 of word 0 is consumed.
- Loop: num_words=3, loop_en=1, base_addr=0x100 -> address sequence 0x100,0x108,0x110,0x100...; no done pulse until stop; after stop, done pulses after outstanding reaches 0.
- Underrun: data latency longer than the tick period at start -> first sample 0x0000 with sample_valid=1 and underrun=1; a new start clears underrun.
- Reset mid-run: sys_rst asserted with 2 reads outstanding -> all outputs at reset values immediately; late app_rd_data_valid ignored; the next start plays correctly from base_addr.

Source files
------------

// File: rtl/ddr3_sample_streamer.sv
// ddr3_sample_streamer
// Reads a contiguous block of 256-bit words from DDR3 through the MIG 7-series
// UI read port. It buffers the words in a small FIFO and plays them out as
// sixteen 16-bit samples per word, one sample per sample_tick.
//
// Ports
//   ui_clk, sys_rst       : MIG UI clock; asynchronous active-high reset
//   init_calib_complete   : MIG calibration done; playback waits for it
//   app_addr/cmd/en/rdy   : UI read command channel (app_cmd is always read)
//   app_rd_data(_valid)   : UI read data return
//   start/stop            : one-cycle playback control pulses
//   base_addr, num_words,
//   loop_en               : playback setup, captured on start
//   sample_tick           : sample-rate strobe
//   sample_out/valid      : sample output; valid pulses one cycle after a tick
//   busy, done, underrun  : status (done pulses, underrun is sticky)
//   state_dbg             : current FSM state, for debug and checkers
//
// Command handshake: app_en is a valid and app_rdy is a ready. A command
// transfers on a cycle with app_en && app_rdy. Once app_en is raised,
// app_en and app_addr stay unchanged until that transfer happens.
//
// Build option: define OFFSET_BINARY_EN to invert bit 15 of every output
// sample. This converts two's complement to offset binary. Silence then
// becomes 16'h8000.
module ddr3_sample_streamer #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 8,
  parameter int CNT_W      = 16
) (
  input  logic             ui_clk,
  input  logic             sys_rst,
  input  logic             init_calib_complete,
  output logic [28:0]      app_addr,
  output logic [2:0]       app_cmd,
  output logic             app_en,
  input  logic             app_rdy,
  input  logic [255:0]     app_rd_data,
  input  logic             app_rd_data_valid,
  input  logic             start,
  input  logic             stop,
  input  logic [28:0]      base_addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic             loop_en,
  input  logic             sample_tick,
  output logic [15:0]      sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic [2:0]       state_dbg
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_C = (OCC_W+1)'(FIFO_DEPTH);
`ifdef OFFSET_BINARY_EN
  localparam logic [15:0] FLIP = 16'h8000;
`else
  localparam logic [15:0] FLIP = 16'h0000;
`endif

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_CAL  = 3'd1,
    S_RUN       = 3'd2,
    S_DRAIN     = 3'd3,
    S_STOP_WAIT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] words_q, issued;
  logic             loop_q;
  logic [28:0]      base_q;
  logic [OCC_W-1:0] outstanding, fifo_count;
  logic [255:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [3:0]       lane;
  logic [255:0]     head;

  logic accept, rd_ok, last_cmd, tick_act, fifo_empty, pop, credit_ok, start_ok;
  logic raise, done_nxt, flush;

  assign app_cmd    = 3'b001;
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;
  assign head       = mem[rd_ptr];
  assign accept     = app_en & app_rdy;
  // Data with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign rd_ok      = app_rd_data_valid && (outstanding != '0);
  assign last_cmd   = accept && (issued == words_q - CNT_W'(1));
  assign fifo_empty = (fifo_count == '0);
  assign tick_act   = sample_tick &&
                      (state == S_WAIT_CAL || state == S_RUN || state == S_DRAIN);
  assign pop        = tick_act && !fifo_empty && (lane == 4'd15);
  // Buffered words plus words in flight must stay below the FIFO size. This
  // guarantees every returned word has a free slot.
  assign credit_ok  = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C;
  assign start_ok   = (state == S_IDLE) && start && (num_words != '0);

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    raise     = 1'b0;
    done_nxt  = 1'b0;
    flush     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (num_words == '0) done_nxt  = 1'b1;
          else                 state_nxt = S_WAIT_CAL;
        end else if (stop) begin
          done_nxt = 1'b1;
        end
      end
      S_WAIT_CAL: begin
        if (stop) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end else if (init_calib_complete) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_STOP_WAIT;
        end else begin
          raise = !app_en && credit_ok;
          if (last_cmd && !loop_q) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Every word is issued. Empty FIFO with nothing in flight means the
        // last sample has been played.
        if (stop) begin
          state_nxt = S_STOP_WAIT;
        end else if (outstanding == '0 && fifo_empty) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      S_STOP_WAIT: begin
        if (!app_en && outstanding == '0) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
          flush     = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (rd_ok) mem[wr_ptr] <= app_rd_data;
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      app_en       <= 1'b0;
      app_addr     <= '0;
      issued       <= '0;
      words_q      <= '0;
      loop_q       <= 1'b0;
      base_q       <= '0;
      outstanding  <= '0;
      fifo_count   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      lane         <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      done         <= done_nxt;
      sample_valid <= 1'b0;

      if (start_ok) begin
        base_q   <= base_addr;
        words_q  <= num_words;
        loop_q   <= loop_en;
        issued   <= '0;
        app_addr <= base_addr;
        underrun <= 1'b0;
      end

      if (raise)       app_en <= 1'b1;
      else if (accept) app_en <= 1'b0;

      if (accept) begin
        if (last_cmd && loop_q) begin
          app_addr <= base_q;
          issued   <= '0;
        end else begin
          app_addr <= app_addr + 29'(ADDR_STEP);
          issued   <= issued + 1'b1;
        end
      end

      case ({accept, rd_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase

      if (rd_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({rd_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (tick_act) begin
        sample_valid <= 1'b1;
        if (!fifo_empty) begin
          sample_out <= head[{lane, 4'b0000} +: 16] ^ FLIP;
          lane       <= lane + 1'b1;
        end else begin
          sample_out <= FLIP;
          underrun   <= 1'b1;
        end
      end

      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        lane       <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ddr3_sample_streamer.sv
`timescale 1ns/1ps
module tb_ddr3_sample_streamer;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;
`ifdef OFFSET_BINARY_EN
  localparam logic [15:0] OB = 16'h8000;
`else
  localparam logic [15:0] OB = 16'h0000;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  always #5 clk = ~clk;

  logic             init_calib_complete = 1'b1;
  logic [28:0]      app_addr;
  logic [2:0]       app_cmd;
  logic             app_en;
  logic             app_rdy = 1'b1;
  logic [255:0]     app_rd_data = '0;
  logic             app_rd_data_valid = 1'b0;
  logic             start = 1'b0, stop = 1'b0, loop_en = 1'b0, sample_tick = 1'b0;
  logic [28:0]      base_addr = '0;
  logic [CNT_W-1:0] num_words = '0;
  logic [15:0]      sample_out;
  logic             sample_valid, busy, done, underrun;
  logic [2:0]       state_dbg;

  ddr3_sample_streamer #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_STEP(8), .CNT_W(CNT_W)) dut (
    .ui_clk(clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .start(start), .stop(stop), .base_addr(base_addr), .num_words(num_words),
    .loop_en(loop_en), .sample_tick(sample_tick), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .done(done), .underrun(underrun),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [28:0] exp_addr_q[$];
  typedef struct { logic [28:0] addr; int due; } pend_t;
  pend_t pend_q[$];
  int cyc = 0, last_due = 0;
  int accepted = 0, returned = 0, sample_cnt = 0, done_cnt = 0;
  int acc_base = 0, samp_base = 0;
  int lat_min = 3, lat_max = 8;
  bit bp_mode = 1'b0;
  int seed = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Memory contents: seed 0 gives lanes numbered consecutively across words.
  function automatic logic [15:0] lane_val(logic [28:0] a, int j);
    logic [31:0] t;
    if (seed == 0) t = (32'(a) >> 3) * 32'd16 + 32'(j);
    else           t = (32'(a) * 32'h9E37_79B1) ^ (32'(j) * 32'h0000_1111) ^ 32'(seed);
    return t[15:0];
  endfunction

  // MIG model: ready/backpressure, command checking, in-order read returns.
  logic        prev_en = 1'b0, prev_acc = 1'b0;
  logic [28:0] prev_addr = '0;
  int          rdy_low = 0;
  always @(negedge clk) begin
    logic acc;
    logic [255:0] d;
    pend_t p;
    cyc++;
    if (!sys_rst && prev_en && !prev_acc) begin
      check("cmd_hold_en", 64'(app_en), 64'd1);
      check("cmd_hold_addr", 64'(app_addr), 64'(prev_addr));
    end
    if (rdy_low > 0) begin
      app_rdy = 1'b0;
      rdy_low--;
    end else if (bp_mode && app_en && !(prev_en && !prev_acc) &&
                 ((accepted - acc_base) % 2 == 1)) begin
      app_rdy = 1'b0;
      rdy_low = 4;
    end else begin
      app_rdy = 1'b1;
    end
    acc = app_en && app_rdy && !sys_rst;
    if (acc) begin
      accepted++;
      if (exp_addr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL cmd_extra actual=%0h required=none", app_addr);
      end else begin
        check("cmd_addr", 64'(app_addr), 64'(exp_addr_q.pop_front()));
      end
      check("credit_limit",
            64'(((accepted - acc_base) - (sample_cnt - samp_base) / 16) <= FIFO_DEPTH), 64'd1);
      p.addr = app_addr;
      p.due  = cyc + $urandom_range(lat_max, lat_min);
      if (p.due <= last_due) p.due = last_due + 1;
      last_due = p.due;
      pend_q.push_back(p);
    end
    prev_en   = app_en;
    prev_acc  = acc;
    prev_addr = app_addr;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      for (int j = 0; j < 16; j++) d[16*j +: 16] = lane_val(p.addr, j);
      app_rd_data       = d;
      app_rd_data_valid = 1'b1;
      returned++;
    end else begin
      app_rd_data_valid = 1'b0;
    end
  end

  // sample monitor
  always @(negedge clk) begin
    if (sample_valid) begin
      sample_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sample_extra actual=%0h required=none", sample_out);
      end else begin
        check("sample", 64'(sample_out), 64'(exp_q.pop_front()));
      end
    end
    if (done) done_cnt++;
  end

  // driver tasks
  task automatic tick_n(int n, int gap);
    repeat (n) begin
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic play(logic [28:0] b, int n, bit lp);
    base_addr = b;
    num_words = CNT_W'(n);
    loop_en   = lp;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic rebase();
    acc_base  = accepted;
    samp_base = sample_cnt;
  endtask

  task automatic expect_words(logic [28:0] b, int n);
    logic [28:0] a;
    for (int i = 0; i < n; i++) begin
      a = b + 29'(i * 8);
      exp_addr_q.push_back(a);
      for (int j = 0; j < 16; j++) exp_q.push_back(lane_val(a, j) ^ OB);
    end
  endtask

  task automatic wait_data(int r0, string name);
    int k = 0;
    while (returned <= r0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (returned <= r0) timeout(name);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(int d0, string name);
    int k = 0;
    while (done_cnt <= d0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (done_cnt <= d0) timeout(name);
    repeat (4) @(negedge clk);
    check({name, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_drained"}, 64'(exp_q.size() + exp_addr_q.size()), 64'd0);
  endtask

  task automatic run_play(logic [28:0] b, int n, int gap, string name);
    int d0 = done_cnt;
    int r0 = returned;
    rebase();
    expect_words(b, n);
    play(b, n, 1'b0);
    check({name, "_busy_start"}, 64'(busy), 64'd1);
    wait_data(r0, {name, "_data"});
    tick_n(n * 16, gap);
    wait_done(d0, name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int d0, r0, k;
    logic [28:0] b;
    repeat (3) @(negedge clk);
    #1;
    check("rst_app_en", 64'(app_en), 64'd0);
    check("rst_app_addr", 64'(app_addr), 64'd0);
    check("rst_app_cmd", 64'(app_cmd), 64'd1);
    check("rst_sample_out", 64'(sample_out), 64'd0);
    check("rst_sample_valid", 64'(sample_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);

    // basic: two words of consecutive lanes
    seed = 0;
    run_play(29'h0, 2, 20, "basic");

    // zero-length start: done next cycle, stays idle
    play(29'h40, 0, 1'b0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("zero_done_once", 64'(done), 64'd0);

    // stop while waiting for calibration
    init_calib_complete = 1'b0;
    play(29'h80, 3, 1'b0);
    repeat (3) @(negedge clk);
    check("cal_wait_busy", 64'(busy), 64'd1);
    check("cal_wait_no_cmd", 64'(app_en), 64'd0);
    pulse_stop();
    check("cal_stop_done", 64'(done), 64'd1);
    check("cal_stop_busy", 64'(busy), 64'd0);
    init_calib_complete = 1'b1;
    repeat (3) @(negedge clk);

    // backpressure on every second command
    seed = $urandom_range(65535, 1);
    bp_mode = 1'b1;
    run_play(29'($urandom) & ~29'h7, 6, 20, "bp");
    bp_mode = 1'b0;

    // credit limit with ticks stopped
    seed = $urandom_range(65535, 1);
    b = 29'($urandom) & ~29'h7;
    d0 = done_cnt;
    rebase();
    expect_words(b, 10);
    play(b, 10, 1'b0);
    repeat (60) @(negedge clk);
    check("credit_cmds_full", 64'(accepted - acc_base), 64'd4);
    check("credit_en_idle", 64'(app_en), 64'd0);
    tick_n(15, 4);
    repeat (10) @(negedge clk);
    check("credit_cmds_lane14", 64'(accepted - acc_base), 64'd4);
    check("credit_en_lane14", 64'(app_en), 64'd0);
    tick_n(1, 4);
    repeat (10) @(negedge clk);
    check("credit_cmds_after_pop", 64'(accepted - acc_base), 64'd5);
    tick_n(144, 8);
    wait_done(d0, "credit");

    // looping playback, then stop
    seed = $urandom_range(65535, 1);
    b = 29'h100;
    d0 = done_cnt;
    r0 = returned;
    rebase();
    for (int i = 0; i < 30; i++) exp_addr_q.push_back(b + 29'((i % 3) * 8));
    for (int i = 0; i < 80; i++)
      exp_q.push_back(lane_val(b + 29'(((i / 16) % 3) * 8), i % 16) ^ OB);
    play(b, 3, 1'b1);
    wait_data(r0, "loop_data");
    tick_n(80, 12);
    check("loop_no_done", 64'(done_cnt - d0), 64'd0);
    check("loop_busy", 64'(busy), 64'd1);
    pulse_stop();
    k = 0;
    while (!done && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!done) timeout("loop_stop_done");
    else check("loop_stop_outstanding", 64'(accepted - returned), 64'd0);
    tick_n(3, 5);
    check("loop_stop_idle", 64'(busy), 64'd0);
    check("loop_samples_used", 64'(exp_q.size()), 64'd0);
    exp_addr_q.delete();

    // underrun at start, sticky until the next start
    seed = $urandom_range(65535, 1);
    lat_min = 30;
    lat_max = 30;
    b = 29'($urandom) & ~29'h7;
    d0 = done_cnt;
    r0 = returned;
    rebase();
    exp_q.push_back(OB);
    expect_words(b, 1);
    play(b, 1, 1'b0);
    @(negedge clk);
    tick_n(1, 2);
    check("underrun_set", 64'(underrun), 64'd1);
    check("underrun_silence_used", 64'(exp_q.size()), 64'd16);
    lat_min = 3;
    lat_max = 8;
    wait_data(r0, "underrun_data");
    tick_n(16, 20);
    wait_done(d0, "underrun");
    check("underrun_sticky", 64'(underrun), 64'd1);
    b = 29'($urandom) & ~29'h7;
    d0 = done_cnt;
    r0 = returned;
    rebase();
    expect_words(b, 1);
    play(b, 1, 1'b0);
    check("underrun_cleared", 64'(underrun), 64'd0);
    wait_data(r0, "clear_data");
    tick_n(16, 20);
    wait_done(d0, "clear");

    // asynchronous reset with reads in flight
    seed = $urandom_range(65535, 1);
    lat_min = 40;
    lat_max = 40;
    b = 29'($urandom) & ~29'h7;
    rebase();
    for (int i = 0; i < 8; i++) exp_addr_q.push_back(b + 29'(i * 8));
    exp_q.push_back(OB);
    play(b, 8, 1'b0);
    tick_n(1, 2);
    k = 0;
    while ((accepted - returned) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if ((accepted - returned) < 2) timeout("rst_mid_outstanding");
    #2 sys_rst = 1'b1;
    #1;
    check("rst_mid_app_en", 64'(app_en), 64'd0);
    check("rst_mid_app_addr", 64'(app_addr), 64'd0);
    check("rst_mid_sample_out", 64'(sample_out), 64'd0);
    check("rst_mid_sample_valid", 64'(sample_valid), 64'd0);
    check("rst_mid_done", 64'(done), 64'd0);
    check("rst_mid_underrun", 64'(underrun), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    k = 0;
    while (pend_q.size() > 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (pend_q.size() > 0) timeout("rst_mid_late_data");
    repeat (5) @(negedge clk);
    check("rst_mid_idle_after_late", 64'(busy), 64'd0);
    exp_addr_q.delete();
    exp_q.delete();
    lat_min = 3;
    lat_max = 8;
    run_play(b, 2, 20, "after_rst");

    // random playbacks, the first one wrapping the 29-bit address space
    for (int t = 0; t < 3; t++) begin
      seed    = $urandom_range(65535, 1);
      lat_min = $urandom_range(6, 2);
      lat_max = lat_min + $urandom_range(6, 0);
      b = (t == 0) ? 29'h1FFF_FFF0 : (29'($urandom) & ~29'h7);
      run_play(b, (t == 0) ? 3 : $urandom_range(5, 1), $urandom_range(24, 16), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
